// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory word, ID/EX hazard fields and branch
// resolution in, program counter and pipeline-register controls out.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [31:0]         instruction;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                idex_mem_read;
  logic [4:0]          idex_rd;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] pc;
  logic                if_id_write;
  logic                if_id_flush;
  logic                id_ex_bubble;
  logic                halted;
  logic [15:0]         stall_count;

  // Pipeline side: supplies fetched word, hazard info and branch outcome.
  modport master (
    output instruction, id_rs1, id_rs2, idex_mem_read, idex_rd,
           branch_taken, branch_target,
    input  pc, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );

  // Sequencer side: consumes hazard info, owns pc and the IF/ID controls.
  modport slave (
    input  instruction, id_rs1, id_rs2, idex_mem_read, idex_rd,
           branch_taken, branch_target,
    output pc, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter and decides each cycle
// between advancing, stalling on a load-use hazard, redirecting on a taken
// branch, and draining the pipeline after a halt word is fetched.
module fetch_sequencer #(
  parameter int          PC_WIDTH     = 8,
  parameter int          RESET_PC     = 0,
  parameter int          PC_STEP      = 4,
  parameter logic [31:0] HALT_WORD    = 32'h0000_0073,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_RESET   = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(PC_STEP);
  localparam logic [15:0]         STALL_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                halted_q, halted_d;
  logic [15:0]         stall_count_q, stall_count_d;

  logic                load_use;
  logic                is_halt_word;
  logic [15:0]         stall_count_inc;
  logic                if_id_write_c;
  logic                if_id_flush_c;
  logic                id_ex_bubble_c;

  // Hazard detection against the instruction in EX; a load writing x0 never
  // creates a dependency. rs2 is compared even when the ID op does not use it.
  always_comb begin
    load_use = bus.idex_mem_read && (bus.idex_rd != 5'd0) &&
               ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));
    is_halt_word = (bus.instruction == HALT_WORD);
    stall_count_inc = (stall_count_q == STALL_MAX) ? stall_count_q
                                                   : stall_count_q + 16'd1;
  end

  // Next-state and pipeline-control decode; branch beats load-use beats halt.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_cnt_d    = drain_cnt_q;
    halted_d       = halted_q;
    stall_count_d  = stall_count_q;
    if_id_write_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          // Redirect: squash the wrong-path word in IF/ID and anything in ID.
          pc_d           = bus.branch_target;
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (load_use) begin
          // Hold pc and IF/ID so the dependent op retries once the load lands.
          id_ex_bubble_c = 1'b1;
          stall_count_d  = stall_count_inc;
        end else if (is_halt_word) begin
          // Let the halt word proceed into ID, then stop fetching.
          if_id_write_c = 1'b1;
          state_d       = DRAIN;
          drain_cnt_d   = '0;
        end else begin
          if_id_write_c = 1'b1;
          pc_d          = pc_q + PC_INC;
        end
      end

      DRAIN: begin
        if_id_flush_c = 1'b1;
        if (bus.branch_taken) begin
          // An older branch still in EX overrules the halt behind it.
          pc_d           = bus.branch_target;
          id_ex_bubble_c = 1'b1;
          state_d        = RUN;
          drain_cnt_d    = '0;
        end else begin
          if (load_use) begin
            id_ex_bubble_c = 1'b1;
            stall_count_d  = stall_count_inc;
          end
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
          end
        end
      end

      HALT: begin
        // Terminal until reset; late branches are ignored.
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
        halted_d       = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Keep the downstream registers quiet while reset is held.
    if (reset) begin
      if_id_write_c  = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= PC_RESET;
      drain_cnt_q   <= '0;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_cnt_q   <= drain_cnt_d;
      halted_q      <= halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.halted       = halted_q;
  assign bus.stall_count  = stall_count_q;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a driver applies one vector per cycle and
// queues the hand-computed outputs; a monitor samples on the falling edge and
// compares against the queue head.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  pc;
    logic        w;
    logic        f;
    logic        b;
    logic        h;
    logic [15:0] sc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   total;
  int   bad;
  int   vec_idx;

  fetch_sequencer_if #(.PC_WIDTH(8)) bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [15:0] idx, input string name,
                       input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL v%0d %s got=%h exp=%h", idx, name, act, req);
    end
  endtask

  // Monitor: one line per transaction, then field-by-field comparison.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("v%0d pc=%h w=%b f=%b b=%b h=%b sc=%0d", e.idx, bus.pc,
                 bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                 bus.halted, bus.stall_count);
        check(e.idx, "pc",     {8'h00, bus.pc},       {8'h00, e.pc});
        check(e.idx, "write",  {15'd0, bus.if_id_write},  {15'd0, e.w});
        check(e.idx, "flush",  {15'd0, bus.if_id_flush},  {15'd0, e.f});
        check(e.idx, "bubble", {15'd0, bus.id_ex_bubble}, {15'd0, e.b});
        check(e.idx, "halted", {15'd0, bus.halted},       {15'd0, e.h});
        check(e.idx, "stalls", bus.stall_count,       e.sc);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [31:0] instr,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic [4:0] rd,
                      input logic bt, input logic [7:0] tgt,
                      input logic [7:0] e_pc, input logic e_w, input logic e_f,
                      input logic e_b, input logic e_h, input logic [15:0] e_sc);
    exp_t e;
    @(posedge clk);
    #2;
    reset             = rst;
    bus.instruction   = instr;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.idex_mem_read = mr;
    bus.idex_rd       = rd;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    e.idx = 16'(vec_idx);
    e.pc  = e_pc;
    e.w   = e_w;
    e.f   = e_f;
    e.b   = e_b;
    e.h   = e_h;
    e.sc  = e_sc;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  // Watchdog so a broken design cannot hang the run.
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    total   = 0;
    bad     = 0;
    vec_idx = 0;
    reset             = 1'b1;
    bus.instruction   = NOP;
    bus.id_rs1        = 5'd0;
    bus.id_rs2        = 5'd0;
    bus.idex_mem_read = 1'b0;
    bus.idex_rd       = 5'd0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;

    //   rst instr  rs1    rs2    mr    rd     bt    tgt     pc     w     f     b     h     sc
    // Reset state: controls forced while reset is held.
    step(1, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    // Sequential advance.
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    // Load-use on rs1 at pc=8: hold.
    step(0, NOP,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    // Load to x0 never stalls.
    step(0, NOP,  5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 8'h00, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    // Load-use through rs2.
    step(0, NOP,  5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    // Branch with simultaneous load-use: branch wins, no stall counted.
    step(0, NOP,  5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 8'h40, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    // Branch beats halt word; target 0xFC to test wrap.
    step(0, HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 8'hFC, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    // Halt at 0x20, three drain cycles (one with a load-use stall), then HALT.
    step(0, HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    step(0, NOP,  5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    // Halted: branch and load-use are ignored.
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h80, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    step(0, NOP,  5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    // Reset from HALT.
    step(1, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    // Halt at 0x04, branch cancels it on the second drain cycle.
    step(0, HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 8'h10, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h14, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    // Halt at 0x18 then reset mid-drain returns to RUN at 0.
    step(0, HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h18, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    step(0, NOP,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
